// File: rtl/shift18_seq_pkg.sv
// Shared types and default sizing for the shift18 command sequencer.
package shift18_seq_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 6;
    localparam int DATA_W    = 64;

    typedef enum logic {
        OP_SHIFT = 1'b0,
        OP_LOAD  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        AMT_SHL1 = 2'b00,
        AMT_SHL8 = 2'b01,
        AMT_ASR1 = 2'b10,
        AMT_ASR8 = 2'b11
    } amt_e;

    typedef struct packed {
        op_e                  op;
        amt_e                 amount;
        logic [DEF_CNT_W-1:0] count;
        logic [DATA_W-1:0]    data;
    } cmd_t;

endpackage

// File: rtl/shift18_cmd_fifo.sv
// Synchronous command FIFO with a DEPTH+1-state occupancy counter.
// Push is ignored when full and pop is ignored when empty.
module shift18_cmd_fifo
    import shift18_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic areset_n,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output logic full,
    output logic empty,
    output cmd_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    cmd_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (occ_r == OCC_W'(DEPTH));
    assign empty  = (occ_r == OCC_W'(0));
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage, pointers (wrap naturally since DEPTH is a power of two) and occupancy.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

endmodule

// File: rtl/shift18_cmd_seq.sv
// Command sequencer feeding the 64-bit arithmetic shifter; expands SHIFT commands into beats.
// Optional SHIFT18_SEQ_STATS_EN adds a 32-bit beat_cnt output counting ena cycles.
module shift18_cmd_seq
    import shift18_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [1:0]        cmd_amount,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              hold,
    output logic              load,
    output logic              ena,
    output logic [1:0]        amount,
    output logic [DATA_W-1:0] data,
    output logic              done,
    output logic              busy
`ifdef SHIFT18_SEQ_STATS_EN
    ,
    output logic [31:0]       beat_cnt
`endif
);

    cmd_t              cmd_in_s;
    cmd_t              head_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              issue_s;
    logic              is_load_s;
    logic              last_s;
    logic              pop_s;
    logic              shift_beat_s;
    logic [CNT_W-1:0]  rem_eff_s;
    logic [CNT_W-1:0]  rem_r;
    logic              rem_valid_r;
    logic              load_r;
    logic              ena_r;
    logic              done_r;
    amt_e              amount_r;
    logic [DATA_W-1:0] data_r;

    assign cmd_ready = !full_s;
    assign busy      = !empty_s;
    assign push_s    = cmd_valid && !full_s;

    // Pack the incoming command into the FIFO entry format.
    always_comb begin
        cmd_in_s        = '0;
        cmd_in_s.op     = op_e'(cmd_op);
        cmd_in_s.amount = amt_e'(cmd_amount);
        cmd_in_s.count  = DEF_CNT_W'(cmd_count);
        cmd_in_s.data   = cmd_data;
    end

    shift18_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .areset_n (areset_n),
        .push     (push_s),
        .din      (cmd_in_s),
        .pop      (pop_s),
        .full     (full_s),
        .empty    (empty_s),
        .head     (head_s)
    );

    // Beat decode: rem_r is only meaningful once the head has issued its first beat.
    always_comb begin
        issue_s   = !hold && !empty_s;
        is_load_s = (head_s.op == OP_LOAD);
        rem_eff_s = rem_valid_r ? rem_r : CNT_W'(head_s.count);
        if (is_load_s) begin
            last_s = 1'b1;
        end else if (rem_eff_s <= CNT_W'(1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
        shift_beat_s = issue_s && !is_load_s && (rem_eff_s != CNT_W'(0));
        pop_s        = issue_s && last_s;
    end

    // Remaining-beat tracking for the FIFO head; frozen while held or idle.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            rem_r       <= '0;
            rem_valid_r <= 1'b0;
        end else if (issue_s) begin
            if (last_s) begin
                rem_r       <= '0;
                rem_valid_r <= 1'b0;
            end else begin
                rem_r       <= rem_eff_s - CNT_W'(1);
                rem_valid_r <= 1'b1;
            end
        end else begin
            rem_r       <= rem_r;
            rem_valid_r <= rem_valid_r;
        end
    end

    // Registered shifter controls; data and amount keep their last issued values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            load_r   <= 1'b0;
            ena_r    <= 1'b0;
            done_r   <= 1'b0;
            amount_r <= AMT_SHL1;
            data_r   <= 64'h0;
        end else begin
            load_r <= issue_s && is_load_s;
            ena_r  <= shift_beat_s;
            done_r <= pop_s;
            if (shift_beat_s) begin
                amount_r <= head_s.amount;
            end
            if (issue_s && is_load_s) begin
                data_r <= head_s.data;
            end
        end
    end

    assign load   = load_r;
    assign ena    = ena_r;
    assign done   = done_r;
    assign amount = amount_r;
    assign data   = data_r;

`ifdef SHIFT18_SEQ_STATS_EN
    logic [31:0] beat_cnt_r;

    // Count every cycle the shifter sees ena; wraps at 2^32.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            beat_cnt_r <= 32'd0;
        end else if (ena_r) begin
            beat_cnt_r <= beat_cnt_r + 32'd1;
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
`else
`endif

endmodule

// File: tb/tb_shift18_cmd_seq.sv
// Directed self-checking bench for shift18_cmd_seq; also checks beat_cnt when
// SHIFT18_SEQ_STATS_EN is defined.
module tb_shift18_cmd_seq;
    import shift18_seq_pkg::*;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [1:0]  cmd_amount;
    logic [5:0]  cmd_count;
    logic [63:0] cmd_data;
    logic        hold;
    logic        load;
    logic        ena;
    logic [1:0]  amount;
    logic [63:0] data;
    logic        done;
    logic        busy;
`ifdef SHIFT18_SEQ_STATS_EN
    logic [31:0] beat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    shift18_cmd_seq dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_amount (cmd_amount),
        .cmd_count  (cmd_count),
        .cmd_data   (cmd_data),
        .hold       (hold),
        .load       (load),
        .ena        (ena),
        .amount     (amount),
        .data       (data),
        .done       (done),
        .busy       (busy)
`ifdef SHIFT18_SEQ_STATS_EN
        ,
        .beat_cnt   (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {load, ena, done}
    task automatic chk_ctl(input string tag, input logic [2:0] exp);
        chk(tag, {61'd0, load, ena, done}, {61'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic op, input logic [1:0] amt, input logic [5:0] cnt,
                           input logic [63:0] d);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_amount = amt;
        cmd_count  = cnt;
        cmd_data   = d;
    endtask

    initial begin
        int ena_seen;
        int done_seen;
        logic [2:0] exp_hold [12];
        areset_n = 1'b0;
        hold     = 1'b0;
        set_cmd(1'b1, 2'b11, 6'd7, 64'hFFFF_0000_FFFF_0000);

        // Reset held with a valid command pending
        tick(); tick(); tick();
        chk_ctl("rst_ctl", 3'b000);
        chk("rst_amount", {62'd0, amount}, 64'd0);
        chk("rst_data", data, 64'h0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        cmd_valid = 1'b0;
        areset_n  = 1'b1;
        tick();
        chk("rel_busy", {63'd0, busy}, 64'd0);
        chk_ctl("rel_ctl", 3'b000);

        // LOAD then SHIFT x3 amount 01, back to back
        set_cmd(1'b1, 2'b00, 6'd0, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("t2_busy", {63'd0, busy}, 64'd1);
        chk_ctl("t2_accept_ctl", 3'b000);
        set_cmd(1'b0, 2'b01, 6'd3, 64'h0);
        tick();
        cmd_valid = 1'b0;
        chk_ctl("t2_load_beat", 3'b101);
        chk("t2_load_data", data, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk_ctl("t2_sh1", 3'b010);
        chk("t2_sh1_amt", {62'd0, amount}, 64'd1);
        tick();
        chk_ctl("t2_sh2", 3'b010);
        chk("t2_sh2_busy", {63'd0, busy}, 64'd1);
        tick();
        chk_ctl("t2_sh3", 3'b011);
        chk("t2_sh3_amt", {62'd0, amount}, 64'd1);
        chk("t2_data_kept", data, 64'hDEAD_BEEF_0123_4567);
        chk("t2_sh3_busy", {63'd0, busy}, 64'd0);
        tick();
        chk_ctl("t2_idle", 3'b000);

        // Fill under hold: DEPTH accepted, the extra one refused
        hold = 1'b1;
        set_cmd(1'b1, 2'b00, 6'd0, 64'h11);
        chk("t3_ready0", {63'd0, cmd_ready}, 64'd1);
        tick();
        set_cmd(1'b0, 2'b10, 6'd1, 64'h0);
        chk("t3_ready1", {63'd0, cmd_ready}, 64'd1);
        tick();
        set_cmd(1'b1, 2'b00, 6'd0, 64'h33);
        chk("t3_ready2", {63'd0, cmd_ready}, 64'd1);
        tick();
        set_cmd(1'b0, 2'b11, 6'd2, 64'h0);
        chk("t3_ready3", {63'd0, cmd_ready}, 64'd1);
        tick();
        set_cmd(1'b1, 2'b00, 6'd0, 64'h55);
        chk("t3_ready_full", {63'd0, cmd_ready}, 64'd0);
        chk_ctl("t3_held_ctl", 3'b000);
        tick();
        cmd_valid = 1'b0;
        chk("t3_still_full", {63'd0, cmd_ready}, 64'd0);
        chk("t3_busy", {63'd0, busy}, 64'd1);
        hold = 1'b0;
        tick();
        chk_ctl("t3_c0_load", 3'b101);
        chk("t3_c0_data", data, 64'h11);
        chk("t3_ready_after_pop", {63'd0, cmd_ready}, 64'd1);
        tick();
        chk_ctl("t3_c1_shift", 3'b011);
        chk("t3_c1_amt", {62'd0, amount}, 64'd2);
        tick();
        chk_ctl("t3_c2_load", 3'b101);
        chk("t3_c2_data", data, 64'h33);
        tick();
        chk_ctl("t3_c3_b1", 3'b010);
        chk("t3_c3_amt", {62'd0, amount}, 64'd3);
        tick();
        chk_ctl("t3_c3_b2", 3'b011);
        tick();
        chk_ctl("t3_no_extra", 3'b000);
        chk("t3_busy_end", {63'd0, busy}, 64'd0);
        chk("t3_data_end", data, 64'h33);

        // SHIFT x5 with a 4-cycle hold after beat 2
        set_cmd(1'b0, 2'b00, 6'd5, 64'h0);
        tick();
        cmd_valid = 1'b0;
        exp_hold = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                     3'b010, 3'b010, 3'b011, 3'b000, 3'b000, 3'b000};
        ena_seen = 0;
        for (int i = 0; i < 12; i++) begin
            hold = (i >= 2 && i < 6);
            tick();
            if (ena) ena_seen++;
            chk($sformatf("t4_cyc%0d", i), {61'd0, load, ena, done}, {61'd0, exp_hold[i]});
        end
        hold = 1'b0;
        chk("t4_ena_total", 64'(ena_seen), 64'd5);
        chk("t4_amt", {62'd0, amount}, 64'd0);

        // LOAD, SHIFT count 0, LOAD
        set_cmd(1'b1, 2'b00, 6'd0, 64'hAA);
        tick();
        set_cmd(1'b0, 2'b01, 6'd0, 64'h0);
        tick();
        chk_ctl("t5_load_a", 3'b101);
        chk("t5_data_a", data, 64'hAA);
        set_cmd(1'b1, 2'b00, 6'd0, 64'hBB);
        tick();
        cmd_valid = 1'b0;
        chk_ctl("t5_count0", 3'b001);
        tick();
        chk_ctl("t5_load_b", 3'b101);
        chk("t5_data_b", data, 64'hBB);
        tick();
        chk_ctl("t5_idle", 3'b000);

        // Reset during beat 2 of a count-10 shift
        set_cmd(1'b0, 2'b11, 6'd10, 64'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_ctl("t6_b1", 3'b010);
        tick();
        chk_ctl("t6_b2", 3'b010);
        areset_n = 1'b0;
        #1;
        chk_ctl("t6_rst_ctl", 3'b000);
        chk("t6_rst_data", data, 64'h0);
        chk("t6_rst_amt", {62'd0, amount}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        areset_n = 1'b1;
        ena_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ena) ena_seen++;
        end
        chk("t6_no_beats_after", 64'(ena_seen), 64'd0);
        chk("t6_busy_after", {63'd0, busy}, 64'd0);
`ifdef SHIFT18_SEQ_STATS_EN
        chk("t6_beat_cnt_zero", {32'd0, beat_cnt}, 64'd0);
`endif
        set_cmd(1'b0, 2'b01, 6'd10, 64'h0);
        tick();
        cmd_valid = 1'b0;
        ena_seen  = 0;
        done_seen = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (ena) ena_seen++;
            if (done) done_seen++;
        end
        chk("t6_fresh_ena", 64'(ena_seen), 64'd10);
        chk("t6_fresh_done", 64'(done_seen), 64'd1);
`ifdef SHIFT18_SEQ_STATS_EN
        chk("t6_beat_cnt_ten", {32'd0, beat_cnt}, 64'd10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift18_cmd_seq.md
# shift18_cmd_seq

Command sequencer that sits directly upstream of the 64-bit arithmetic shift register and drives its `load`/`ena`/`amount`/`data` inputs. It accepts load and multi-step shift commands over a valid/ready handshake and buffers them in a small FIFO. It expands each shift command into `count` consecutive single-step beats, issuing back-to-back with no bubbles between commands. A `hold` input pauses issue without losing state.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `CNT_W`, 6: width of per-command shift repeat count.

- `clk`  in  1  rising-edge clock.
- `areset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept.
- `cmd_op`  in  1  0 = SHIFT, 1 = LOAD.
- `cmd_amount`  in  2  shift code: 00 shl1, 01 shl8, 10 asr1, 11 asr8.
- `cmd_count`  in  CNT_W  number of shift beats (SHIFT only).
- `cmd_data`  in  64  load value (LOAD only).
- `hold`  in  1  pause issue.
- `load`  out  1  to shifter `load`.
- `ena`  out  1  to shifter `ena`.
- `amount`  out  2  to shifter `amount`.
- `data`  out  64  to shifter `data`.
- `done`  out  1  one-cycle pulse with final beat of each command.
- `busy`  out  1  FIFO non-empty.

## Operation
- Accept on `cmd_valid && cmd_ready`. `cmd_ready = !full`, with no pass-through when full, even if a pop occurs in the same cycle.
- The issue engine reads the FIFO head combinationally. It tracks `rem` (remaining beats of the head) and registers one beat per un-held cycle.
- LOAD head: one beat with `load=1`, `ena=0`, `data=cmd_data`. The head is popped and `done=1` in that beat.
- SHIFT head, count N>0: N beats of `ena=1`, `load=0`, `amount=cmd_amount`. The head is popped and `done=1` on beat N.
- SHIFT head, count 0: one retire cycle with `load=ena=0` and `done=1`. The head is popped.
- When the last beat of one command is registered, the next head's first beat is registered on the following edge. There are no idle cycles.
- `hold=1`: `load`, `ena`, and `done` are registered 0, and `rem` and the FIFO head are frozen. Pushes are still accepted. Issue resumes mid-command on the first edge with `hold=0`.
- `data` updates only on LOAD beats and otherwise holds its last value. `amount` updates only on SHIFT beats.
- Empty FIFO: `load=ena=done=0`.
- Simultaneous push and pop in a non-full FIFO: both take effect and occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a DEPTH+1-state counter.

## Timing
- Reset (async assert, sync-safe release) sets `load`, `ena`, `done`, `amount` = 0, `data` = 64'h0, `cmd_ready` = 1, `busy` = 0. Pointers, occupancy and `rem` are cleared.
- Reset mid-command discards all pending and partially issued commands.
- Latency: a command accepted at edge k has its first beat on outputs after edge k+1. The shifter consumes it at edge k+2.
- All outputs except `cmd_ready` and `busy` are registered. `cmd_ready` and `busy` decode registered occupancy with no input-to-output combinational path.
- A SHIFT command of count N that is never held occupies exactly N issue cycles. LOAD and count-0 commands occupy 1 cycle.

## Configuration
- `SHIFT18_SEQ_STATS_EN` defined: adds output port `beat_cnt` (32 bits). It counts every cycle with `ena=1`, wraps at 2^32, and resets to 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `shift18_seq_pkg` holds:
  - `op_e` (OP_SHIFT, OP_LOAD).
  - `amt_e` (AMT_SHL1, AMT_SHL8, AMT_ASR1, AMT_ASR8).
  - `cmd_t` packed struct {op, amount, count, data}.
  - Default `DEPTH` and `CNT_W` constants.
- Sub-module `shift18_cmd_fifo` is a parameterised synchronous FIFO of `cmd_t` with push/pop/full/empty/head and async active-low reset. The issue engine and the stats counter live in the top.

## Test plan
- Reset with `cmd_valid=1` held: all outputs 0, `cmd_ready=1`, nothing accepted until release.
- LOAD `data=64'hDEAD_BEEF_0123_4567`, then SHIFT amount 01 count 3 → one `load` beat with that data, then exactly 3 `ena` beats with `amount=01`. `done` pulses on the load beat and on the 3rd shift beat, with no gap between commands.
- Push DEPTH+1 commands with `hold=1`: `cmd_ready` drops after DEPTH accepts and the extra command is not accepted. Release hold and all DEPTH commands issue in order.
- SHIFT count 5 with `hold` asserted after beat 2 for 4 cycles → beats resume at 3 and a total of 5 `ena` beats are issued. `done` occurs only with beat 5.
- SHIFT count 0 between two LOADs → the middle cycle has `load=ena=0` and `done=1`.
- Assert `areset_n=0` during beat 2 of count 10: outputs clear immediately and no further beats occur after release. With `SHIFT18_SEQ_STATS_EN`, `beat_cnt` reads 0 after reset and 10 after a fresh count-10 command.
